// File: rtl/syn_fifo_flags.sv
// syn_fifo_flags: single-clock FIFO with registered or first-word-fall-through read,
// occupancy count, programmable almost flags and one-cycle overflow/underflow pulses.
module syn_fifo_flags #(
    parameter int data_width = 8,
    parameter int depth      = 512,
    parameter int fwft       = 0,
    parameter int af_level   = depth - 4,
    parameter int ae_level   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [data_width-1:0]   wr_data,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [data_width-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(depth):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] af_cnt = (aw + 1)'(af_level);
    localparam logic [aw:0] ae_cnt = (aw + 1)'(ae_level);

    generate
        if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
            $error("syn_fifo_flags: depth must be a power of two >= 2");
        end
        if (af_level < 1 || af_level > depth) begin : g_bad_af
            $error("syn_fifo_flags: af_level must be in 1..depth");
        end
        if (ae_level < 0 || ae_level > depth - 1) begin : g_bad_ae
            $error("syn_fifo_flags: ae_level must be in 0..depth-1");
        end
    endgenerate

    logic [data_width-1:0] mem [depth];
    logic [aw:0]           wr_ptr, rd_ptr;
    logic                  wr_ok, rd_ok;

    // Wrap bit disambiguates full from empty when the indices coincide.
    assign full         = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign empty        = wr_ptr == rd_ptr;
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = count >= af_cnt;
    assign almost_empty = count <= ae_cnt;
    assign wr_ok        = wr_en && !full;
    assign rd_ok        = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ok ? wr_ptr + (aw + 1)'(1) : wr_ptr;
            rd_ptr    <= rd_ok ? rd_ptr + (aw + 1)'(1) : rd_ptr;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[aw-1:0]] <= wr_data;
    end

    generate
        if (fwft != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr[aw-1:0]];
            assign rd_valid = !empty;
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_ok;
                    if (rd_ok) rd_data <= mem[rd_ptr[aw-1:0]];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_syn_fifo_flags.sv
// tb_syn_fifo_flags: directed bench for a registered-read and an FWFT instance (depth 8).
module tb_syn_fifo_flags;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic [7:0] f_wr_data = '0;
    logic       f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    syn_fifo_flags #(.data_width(8), .depth(8), .fwft(0), .af_level(6), .ae_level(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    syn_fifo_flags #(.data_width(8), .depth(8), .fwft(1), .af_level(6), .ae_level(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_data(f_wr_data), .wr_en(f_wr_en), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL reset_empty: got %b want 1", empty); end
        tests++; if (full !== 1'b0) begin failed++; $display("FAIL reset_full: got %b want 0", full); end
        tests++; if (almost_empty !== 1'b1) begin failed++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
        tests++; if (almost_full !== 1'b0) begin failed++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
        tests++; if (count !== 4'd0) begin failed++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        tests++; if (rd_data !== 8'h00) begin failed++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        tests++; if ({overflow, underflow} !== 2'b00) begin failed++; $display("FAIL reset_errs: got %b want 00", {overflow, underflow}); end
        step();
        step();
        rst_n = 1'b1;
        step();
        // Mid-transfer: push 5 words and pop one so rd_data/rd_valid are non-zero, then reset between edges
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
            step();
        end
        wr_en = 1'b1; wr_data = 8'hC5; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        tests++; if (count !== 4'd5) begin failed++; $display("FAIL pre_reset_count: got %0d want 5", count); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (count !== 4'd0) begin failed++; $display("FAIL async_reset_count: got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL async_reset_empty: got %b want 1", empty); end
        tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL async_reset_rd_valid: got %b want 0", rd_valid); end
        tests++; if (rd_data !== 8'h00) begin failed++; $display("FAIL async_reset_rd_data: got %h want 00", rd_data); end
        tests++; if (almost_empty !== 1'b1) begin failed++; $display("FAIL async_reset_almost_empty: got %b want 1", almost_empty); end
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            tests++; if (count !== 4'(i)) begin failed++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            tests++; if (almost_full !== (i >= 6)) begin failed++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, almost_full, i >= 6); end
            tests++; if (full !== (i == 8)) begin failed++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == 8); end
            tests++; if (almost_empty !== (i <= 2)) begin failed++; $display("FAIL fill_almost_empty[%0d]: got %b want %b", i, almost_empty, i <= 2); end
        end
        wr_data = 8'h09;
        step();
        tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL overflow_pulse: got %b want 1", overflow); end
        tests++; if (count !== 4'd8) begin failed++; $display("FAIL overflow_count: got %0d want 8", count); end
        wr_en = 1'b0;
        step();
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL overflow_clear: got %b want 0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            step();
            tests++; if (rd_valid !== 1'b1) begin failed++; $display("FAIL drain_valid[%0d]: got %b want 1", i, rd_valid); end
            tests++; if (rd_data !== 8'(i)) begin failed++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, 8'(i)); end
            tests++; if (count !== 4'(8 - i)) begin failed++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 8 - i); end
            tests++; if (empty !== (i == 8)) begin failed++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty, i == 8); end
        end
        step();
        tests++; if (underflow !== 1'b1) begin failed++; $display("FAIL underflow_pulse: got %b want 1", underflow); end
        tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL underflow_valid: got %b want 0", rd_valid); end
        tests++; if (rd_data !== 8'h08) begin failed++; $display("FAIL underflow_hold: got %h want 08", rd_data); end
        rd_en = 1'b0;
        step();
        tests++; if (underflow !== 1'b0) begin failed++; $display("FAIL underflow_clear: got %b want 0", underflow); end
        tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL valid_drop: got %b want 0", rd_valid); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'h40 + 8'(n); exp_q.push_back(wr_data); n++;
            step();
        end
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h40 + 8'(n); exp_q.push_back(wr_data); n++;
            step();
            e = exp_q.pop_front();
            tests++; if (count !== 4'd3) begin failed++; $display("FAIL wrap_count[%0d]: got %0d want 3", i, count); end
            tests++; if (rd_valid !== 1'b1 || rd_data !== e) begin failed++; $display("FAIL wrap_data[%0d]: got %b/%h want 1/%h", i, rd_valid, rd_data, e); end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_q.pop_front();
            tests++; if (rd_valid !== 1'b1 || rd_data !== e) begin failed++; $display("FAIL wrap_tail[%0d]: got %b/%h want 1/%h", i, rd_valid, rd_data, e); end
        end
        rd_en = 1'b0;
        step();
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_empty_both();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h90 + 8'(i);
            step();
        end
        wr_data = 8'hEE; rd_en = 1'b1;
        step();
        tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL full_both_overflow: got %b want 1", overflow); end
        tests++; if (count !== 4'd7) begin failed++; $display("FAIL full_both_count: got %0d want 7", count); end
        tests++; if (rd_valid !== 1'b1 || rd_data !== 8'h90) begin failed++; $display("FAIL full_both_read: got %b/%h want 1/90", rd_valid, rd_data); end
        wr_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            tests++; if (rd_data !== 8'h90 + 8'(i)) begin failed++; $display("FAIL full_both_drain[%0d]: got %h want %h", i, rd_data, 8'h90 + 8'(i)); end
        end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL full_both_empty: got %b want 1", empty); end
        wr_en = 1'b1; wr_data = 8'hAB;
        step();
        tests++; if (underflow !== 1'b1) begin failed++; $display("FAIL empty_both_underflow: got %b want 1", underflow); end
        tests++; if (count !== 4'd1) begin failed++; $display("FAIL empty_both_count: got %0d want 1", count); end
        tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL empty_both_valid: got %b want 0", rd_valid); end
        wr_en = 1'b0;
        step();
        tests++; if (rd_valid !== 1'b1 || rd_data !== 8'hAB) begin failed++; $display("FAIL empty_both_read: got %b/%h want 1/ab", rd_valid, rd_data); end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_fwft();
        tests++; if (f_rd_valid !== 1'b0) begin failed++; $display("FAIL fwft_idle_valid: got %b want 0", f_rd_valid); end
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        step();
        f_wr_en = 1'b0;
        tests++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hA5) begin failed++; $display("FAIL fwft_head: got %b/%h want 1/a5", f_rd_valid, f_rd_data); end
        step();
        tests++; if (f_rd_valid !== 1'b1 || f_count !== 4'd1) begin failed++; $display("FAIL fwft_hold: got %b/%0d want 1/1", f_rd_valid, f_count); end
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        tests++; if (f_rd_valid !== 1'b0 || f_empty !== 1'b1) begin failed++; $display("FAIL fwft_pop: got %b/%b want 0/1", f_rd_valid, f_empty); end
        f_wr_en = 1'b1; f_wr_data = 8'hB1;
        step();
        f_wr_data = 8'hB2;
        step();
        f_wr_en = 1'b0;
        tests++; if (f_rd_data !== 8'hB1 || f_count !== 4'd2) begin failed++; $display("FAIL fwft_head2: got %h/%0d want b1/2", f_rd_data, f_count); end
        f_rd_en = 1'b1;
        step();
        tests++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hB2) begin failed++; $display("FAIL fwft_next: got %b/%h want 1/b2", f_rd_valid, f_rd_data); end
        step();
        step();
        f_rd_en = 1'b0;
        tests++; if (f_underflow !== 1'b1 || f_rd_valid !== 1'b0) begin failed++; $display("FAIL fwft_underflow: got %b/%b want 1/0", f_underflow, f_rd_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_empty_both();
        test_fwft();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
